mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: MEM_STAGE

---
 rtl/mem_stage_pkg.sv | 34 +++
 rtl/mem_stage_if.sv | 26 ++
 rtl/MEM_WB_Register.sv | 24 ++
 rtl/mem_stage.sv | 153 +++++++++++++++
 tb/tb_mem_stage.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory stage.
// Contents: MEM FSM state encoding, default access timeout, the MEM/WB
// register field layout, and the bubble value loaded on stalled cycles.
package mem_stage_pkg;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  localparam logic [3:0] AVM_BYTEENABLE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WR_REQ  = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic        mem_to_reg;
    logic        reg_write;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  write_reg;
  } mem_wb_t;

  // A bubble never writes the register file.
  localparam mem_wb_t MEM_WB_BUBBLE = '{
    mem_to_reg: 1'b0,
    reg_write:  1'b0,
    read_data:  32'd0,
    alu_result: 32'd0,
    write_reg:  5'd0
  };

endpackage

// File: rtl/mem_stage_if.sv
// Avalon-MM style data bus between the memory stage (master) and memory (slave).
// Handshake: a command (avm_read or avm_write) is held stable with its address
// and data until a cycle in which avm_waitrequest=0; that cycle accepts it.
// Read data returns later on any cycle with avm_readdatavalid=1.
// Signals: avm_address/avm_writedata/avm_byteenable/avm_read/avm_write from the
// master; avm_readdata/avm_waitrequest/avm_readdatavalid from the slave.
interface mem_stage_if;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_readdata, avm_waitrequest, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_readdata, avm_waitrequest, avm_readdatavalid
  );
endinterface

// File: rtl/MEM_WB_Register.sv
// MEM/WB pipeline register.
// Ports: clk, rst (async, active-high), load_bubble (load the bubble value
// instead of d), d (next MEM/WB fields), q (current MEM/WB fields).
module MEM_WB_Register
  import mem_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load_bubble,
  input  mem_wb_t d,
  output mem_wb_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= MEM_WB_BUBBLE;
    end else if (load_bubble) begin
      q <= MEM_WB_BUBBLE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: turns EX/MEM loads and stores into bus accesses,
// stalls the front of the pipe while an access is outstanding, and feeds the
// MEM/WB register.
// Ports: clk, rst; EX_MEM_* control/data from EX/MEM; avm (bus master);
// MEM_Stall freeze request; MEM_WB_* register outputs; MEM_Data forwarding
// value; MEM_BusError sticky error flag; dbg_state current FSM state.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               EX_MEM_MemToReg,
  input  logic               EX_MEM_RegWrite,
  input  logic               EX_MEM_MemRead,
  input  logic               EX_MEM_MemWrite,
  input  logic [31:0]        EX_MEM_ALUResult,
  input  logic [31:0]        EX_MEM_WriteData,
  input  logic [4:0]         EX_MEM_WriteReg,
  mem_stage_if.master        avm,
  output logic               MEM_Stall,
  output logic               MEM_WB_MemToReg,
  output logic               MEM_WB_RegWrite,
  output logic [31:0]        MEM_WB_ReadData,
  output logic [31:0]        MEM_WB_ALUResult,
  output logic [4:0]         MEM_WB_WriteReg,
  output logic [31:0]        MEM_Data,
  output logic               MEM_BusError,
  output mem_state_e         dbg_state
);

  mem_state_e  state;
  logic [7:0]  tmo_cnt;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_mem_to_reg;
  logic        acc_reg_write;
  logic [4:0]  acc_write_reg;
  logic        bus_error;

  logic        mem_req;
  logic        tmo;
  logic        rd_done;
  logic        nat_done;
  logic        force_done;
  logic        complete;
  logic        stall;
  mem_wb_t     wb_d;
  mem_wb_t     wb_q;

  always_comb begin
    mem_req  = EX_MEM_MemRead | EX_MEM_MemWrite;
    // Timeout fires in the TIMEOUT_CYCLES-th non-IDLE cycle of an access.
    tmo      = (state != ST_IDLE) && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
    rd_done  = (state == ST_RD_WAIT) && avm.avm_readdatavalid;
    // A write only counts as accepted while the command is still driven.
    nat_done = rd_done || ((state == ST_WR_REQ) && !avm.avm_waitrequest && !tmo);
    force_done = tmo && !nat_done;
    complete = nat_done || force_done;
    stall    = (state == ST_IDLE) ? mem_req : !complete;

    wb_d = MEM_WB_BUBBLE;
    if (state == ST_IDLE) begin
      wb_d.mem_to_reg = EX_MEM_MemToReg;
      wb_d.reg_write  = EX_MEM_RegWrite;
      wb_d.alu_result = EX_MEM_ALUResult;
      wb_d.write_reg  = EX_MEM_WriteReg;
    end else begin
      wb_d.mem_to_reg = acc_mem_to_reg;
      wb_d.reg_write  = acc_reg_write;
      wb_d.alu_result = acc_addr;
      wb_d.write_reg  = acc_write_reg;
      wb_d.read_data  = rd_done ? avm.avm_readdata : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      tmo_cnt        <= 8'd0;
      acc_addr       <= 32'd0;
      acc_wdata      <= 32'd0;
      acc_mem_to_reg <= 1'b0;
      acc_reg_write  <= 1'b0;
      acc_write_reg  <= 5'd0;
      bus_error      <= 1'b0;
    end else begin
      if (state != ST_IDLE) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      case (state)
        ST_IDLE: begin
          if (mem_req) begin
            acc_addr       <= {EX_MEM_ALUResult[31:2], 2'b00};
            acc_wdata      <= EX_MEM_WriteData;
            acc_mem_to_reg <= EX_MEM_MemToReg;
            acc_reg_write  <= EX_MEM_RegWrite;
            acc_write_reg  <= EX_MEM_WriteReg;
            tmo_cnt        <= 8'd0;
            // A simultaneous read and write is serviced as a write.
            state <= EX_MEM_MemWrite ? ST_WR_REQ : ST_RD_REQ;
            if (EX_MEM_MemRead && EX_MEM_MemWrite) begin
              bus_error <= 1'b1;
            end
          end
        end
        ST_RD_REQ: begin
          if (tmo) begin
            state <= ST_IDLE;
          end else if (!avm.avm_waitrequest) begin
            state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT, ST_WR_REQ: begin
          if (complete) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (force_done) begin
        bus_error <= 1'b1;
      end
    end
  end

  MEM_WB_Register u_mem_wb (
    .clk         (clk),
    .rst         (rst),
    .load_bubble (stall),
    .d           (wb_d),
    .q           (wb_q)
  );

  // Commands are decoded from registered state; a timeout drops them at once.
  assign avm.avm_address    = acc_addr;
  assign avm.avm_read       = (state == ST_RD_REQ) && !tmo;
  assign avm.avm_write      = (state == ST_WR_REQ) && !tmo;
  assign avm.avm_writedata  = acc_wdata;
  assign avm.avm_byteenable = AVM_BYTEENABLE;

  assign MEM_Stall        = stall && !rst;
  assign MEM_WB_MemToReg  = wb_q.mem_to_reg;
  assign MEM_WB_RegWrite  = wb_q.reg_write;
  assign MEM_WB_ReadData  = wb_q.read_data;
  assign MEM_WB_ALUResult = wb_q.alu_result;
  assign MEM_WB_WriteReg  = wb_q.write_reg;
  assign MEM_Data         = wb_q.mem_to_reg ? wb_q.read_data : wb_q.alu_result;
  assign MEM_BusError     = bus_error;
  assign dbg_state        = state;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        EX_MEM_MemToReg;
  logic        EX_MEM_RegWrite;
  logic        EX_MEM_MemRead;
  logic        EX_MEM_MemWrite;
  logic [31:0] EX_MEM_ALUResult;
  logic [31:0] EX_MEM_WriteData;
  logic [4:0]  EX_MEM_WriteReg;
  logic        MEM_Stall;
  logic        MEM_WB_MemToReg;
  logic        MEM_WB_RegWrite;
  logic [31:0] MEM_WB_ReadData;
  logic [31:0] MEM_WB_ALUResult;
  logic [4:0]  MEM_WB_WriteReg;
  logic [31:0] MEM_Data;
  logic        MEM_BusError;
  mem_state_e  dbg_state;

  int n_checks = 0;
  int n_fails  = 0;
  int stall_cycles;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT_CYCLES(255)) dut (
    .clk              (clk),
    .rst              (rst),
    .EX_MEM_MemToReg  (EX_MEM_MemToReg),
    .EX_MEM_RegWrite  (EX_MEM_RegWrite),
    .EX_MEM_MemRead   (EX_MEM_MemRead),
    .EX_MEM_MemWrite  (EX_MEM_MemWrite),
    .EX_MEM_ALUResult (EX_MEM_ALUResult),
    .EX_MEM_WriteData (EX_MEM_WriteData),
    .EX_MEM_WriteReg  (EX_MEM_WriteReg),
    .avm              (bus.master),
    .MEM_Stall        (MEM_Stall),
    .MEM_WB_MemToReg  (MEM_WB_MemToReg),
    .MEM_WB_RegWrite  (MEM_WB_RegWrite),
    .MEM_WB_ReadData  (MEM_WB_ReadData),
    .MEM_WB_ALUResult (MEM_WB_ALUResult),
    .MEM_WB_WriteReg  (MEM_WB_WriteReg),
    .MEM_Data         (MEM_Data),
    .MEM_BusError     (MEM_BusError),
    .dbg_state        (dbg_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ex_clear();
    EX_MEM_MemToReg  = 1'b0;
    EX_MEM_RegWrite  = 1'b0;
    EX_MEM_MemRead   = 1'b0;
    EX_MEM_MemWrite  = 1'b0;
    EX_MEM_ALUResult = 32'd0;
    EX_MEM_WriteData = 32'd0;
    EX_MEM_WriteReg  = 5'd0;
  endtask

  task automatic ex_drive(input logic m2r, input logic rw, input logic mr, input logic mw,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
    EX_MEM_MemToReg  = m2r;
    EX_MEM_RegWrite  = rw;
    EX_MEM_MemRead   = mr;
    EX_MEM_MemWrite  = mw;
    EX_MEM_ALUResult = alu;
    EX_MEM_WriteData = wd;
    EX_MEM_WriteReg  = wr;
  endtask

  initial begin
    // Reset state, with a pending load that must not stall during reset
    rst = 1'b1;
    ex_clear();
    EX_MEM_MemRead = 1'b1;
    bus.avm_readdata      = 32'd0;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    #1;
    chk("rst_stall", MEM_Stall, 0);
    chk("rst_read", bus.avm_read, 0);
    chk("rst_write", bus.avm_write, 0);
    chk("rst_wb_alu", MEM_WB_ALUResult, 0);
    chk("rst_wb_rw", MEM_WB_RegWrite, 0);
    chk("rst_buserr", MEM_BusError, 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    ex_clear();
    rst = 1'b0;

    // ALU op passes through in one cycle
    @(negedge clk);
    ex_drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h1234, 32'd0, 5'd5);
    #1 chk("alu_stall", MEM_Stall, 0);
    @(negedge clk);
    #1;
    chk("alu_wb_alu", MEM_WB_ALUResult, 32'h1234);
    chk("alu_data", MEM_Data, 32'h1234);
    chk("alu_wb_rw", MEM_WB_RegWrite, 1);
    chk("alu_wb_wr", MEM_WB_WriteReg, 5);
    chk("alu_stall2", MEM_Stall, 0);
    ex_clear();

    // Load from 0x103: waitrequest for 2 cycles, data the cycle after accept
    @(negedge clk);
    ex_drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h103, 32'd0, 5'd7);
    bus.avm_waitrequest = 1'b1;
    #1;
    chk("ld_c0_stall", MEM_Stall, 1);
    chk("ld_c0_read", bus.avm_read, 0);
    @(negedge clk);
    ex_clear();
    #1;
    chk("ld_c1_stall", MEM_Stall, 1);
    chk("ld_c1_read", bus.avm_read, 1);
    chk("ld_c1_addr", bus.avm_address, 32'h100);
    chk("ld_c1_write", bus.avm_write, 0);
    @(negedge clk);
    #1;
    chk("ld_c2_stall", MEM_Stall, 1);
    chk("ld_c2_read", bus.avm_read, 1);
    chk("ld_c2_bubble", MEM_WB_RegWrite, 0);
    @(negedge clk);
    bus.avm_waitrequest = 1'b0;
    #1;
    chk("ld_c3_stall", MEM_Stall, 1);
    chk("ld_c3_read", bus.avm_read, 1);
    @(negedge clk);
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata      = 32'hCAFEBABE;
    #1;
    chk("ld_c4_read", bus.avm_read, 0);
    chk("ld_c4_stall", MEM_Stall, 0);
    chk("ld_c4_state", 32'(dbg_state), 32'(ST_RD_WAIT));
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = 32'd0;
    #1;
    chk("ld_wb_rdata", MEM_WB_ReadData, 32'hCAFEBABE);
    chk("ld_data", MEM_Data, 32'hCAFEBABE);
    chk("ld_wb_rw", MEM_WB_RegWrite, 1);
    chk("ld_wb_wr", MEM_WB_WriteReg, 7);
    chk("ld_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("ld_stall_after", MEM_Stall, 0);

    // Store 0xDEADBEEF to 0x200 with no wait states
    @(negedge clk);
    ex_drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 5'd0);
    #1;
    chk("st_c0_stall", MEM_Stall, 1);
    chk("st_c0_write", bus.avm_write, 0);
    @(negedge clk);
    ex_clear();
    #1;
    chk("st_c1_write", bus.avm_write, 1);
    chk("st_c1_wdata", bus.avm_writedata, 32'hDEADBEEF);
    chk("st_c1_addr", bus.avm_address, 32'h200);
    chk("st_c1_be", bus.avm_byteenable, 4'hF);
    chk("st_c1_read", bus.avm_read, 0);
    chk("st_c1_stall", MEM_Stall, 0);
    chk("st_c1_bubble", MEM_WB_RegWrite, 0);
    @(negedge clk);
    #1;
    chk("st_c2_write", bus.avm_write, 0);
    chk("st_c2_wb_rw", MEM_WB_RegWrite, 0);
    chk("st_c2_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("st_buserr", MEM_BusError, 0);

    // Load to a slave that never accepts: forced completion after timeout
    @(negedge clk);
    ex_drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'd0, 5'd9);
    bus.avm_waitrequest = 1'b1;
    @(negedge clk);
    ex_clear();
    #1;
    stall_cycles = 0;
    while (MEM_Stall && stall_cycles < 400) begin
      stall_cycles++;
      @(negedge clk);
      #1;
    end
    chk("tmo_stall_cycles", stall_cycles, 254);
    chk("tmo_read_drop", bus.avm_read, 0);
    @(negedge clk);
    bus.avm_waitrequest = 1'b0;
    #1;
    chk("tmo_buserr", MEM_BusError, 1);
    chk("tmo_wb_rdata", MEM_WB_ReadData, 0);
    chk("tmo_data", MEM_Data, 0);
    chk("tmo_wb_rw", MEM_WB_RegWrite, 1);
    chk("tmo_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("tmo_stall", MEM_Stall, 0);

    // Reset pulsed in RD_WAIT
    @(negedge clk);
    ex_drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h80, 32'd0, 5'd4);
    @(negedge clk);
    ex_clear();
    @(negedge clk);
    #1 chk("rr_pre_state", 32'(dbg_state), 32'(ST_RD_WAIT));
    rst = 1'b1;
    #1;
    chk("rr_stall", MEM_Stall, 0);
    chk("rr_read", bus.avm_read, 0);
    chk("rr_buserr", MEM_BusError, 0);
    chk("rr_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata      = 32'h5555AAAA;
    #1;
    chk("rr_stray_stall", MEM_Stall, 0);
    chk("rr_stray_read", bus.avm_read, 0);
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = 32'd0;
    ex_drive(1'b0, 1'b1, 1'b0, 1'b0, 32'hABCD, 32'd0, 5'd3);
    #1;
    chk("rr_stray_rdata", MEM_WB_ReadData, 0);
    chk("rr_alu_stall", MEM_Stall, 0);
    @(negedge clk);
    ex_clear();
    #1;
    chk("rr_alu_wb", MEM_WB_ALUResult, 32'hABCD);
    chk("rr_alu_data", MEM_Data, 32'hABCD);

    // Read and write together: serviced as one write, error flagged
    @(negedge clk);
    ex_drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h302, 32'h12345678, 5'd0);
    bus.avm_waitrequest = 1'b0;
    #1 chk("cf_c0_stall", MEM_Stall, 1);
    @(negedge clk);
    ex_clear();
    #1;
    chk("cf_c1_write", bus.avm_write, 1);
    chk("cf_c1_read", bus.avm_read, 0);
    chk("cf_c1_addr", bus.avm_address, 32'h300);
    chk("cf_c1_stall", MEM_Stall, 0);
    @(negedge clk);
    #1;
    chk("cf_c2_write", bus.avm_write, 0);
    chk("cf_buserr", MEM_BusError, 1);
    chk("cf_state", 32'(dbg_state), 32'(ST_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
